mdu_ctrl: RTL

Multiply/divide unit controller for the five-stage MIPS pipeline. It sits in the E stage beside the ALU, owns the HI/LO registers, and sequences multi-cycle MULT/MULTU/DIV/DIVU operations. It also handles MTHI/MTLO writes and MFHI/MFLO reads, and raises the stall request the hazard unit uses to freeze D while the unit is occupied.

---
 rtl/mdu_ctrl_if.sv | 24 ++
 rtl/mdu_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl_if.sv
// E-stage multiply/divide bus: operation request, operands and hazard hint in,
// status, HI/LO and MFHI/MFLO read data out.
interface mdu_ctrl_if;
   logic [3:0]  md_op;
   logic        start;
   logic [31:0] A;
   logic [31:0] B;
   logic        D_md_use;
   logic        busy;
   logic        stall_md;
   logic [31:0] md_out;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output md_op, start, A, B, D_md_use,
      input  busy, stall_md, md_out, HI, LO
   );

   modport slave (
      input  md_op, start, A, B, D_md_use,
      output busy, stall_md, md_out, HI, LO
   );
endinterface

// File: rtl/mdu_ctrl.sv
// MIPS E-stage multiply/divide controller: owns HI/LO, times MULT/DIV as a
// fixed-length busy window and drives the D-stage stall request.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic         clk,
   input  logic         reset,
   mdu_ctrl_if.slave    bus
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_MTHI  = 4'd7,
      OP_MTLO  = 4'd8
   } md_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   md_op_e            op_q, op_d;
   logic [31:0]       a_q, a_d;
   logic [31:0]       b_q, b_d;
   logic [31:0]       hi_q, hi_d;
   logic [31:0]       lo_q, lo_d;

   // Request decode
   logic is_mul_op;
   logic is_div_op;
   logic start_ok;

   assign is_mul_op = (bus.md_op == OP_MULT) || (bus.md_op == OP_MULTU);
   assign is_div_op = (bus.md_op == OP_DIV)  || (bus.md_op == OP_DIVU);
   assign start_ok  = bus.start && (is_mul_op || is_div_op);

   // Arithmetic on the latched operands only
   logic signed [63:0] a_sx, b_sx;
   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic               div_by_zero;
   logic               div_ovf;
   logic        [31:0] sdiv_den;
   logic        [31:0] udiv_den;
   logic        [31:0] quot_s, rem_s;
   logic        [31:0] quot_u, rem_u;

   assign a_sx   = {{32{a_q[31]}}, a_q};
   assign b_sx   = {{32{b_q[31]}}, b_q};
   assign prod_s = a_sx * b_sx;
   assign prod_u = {32'd0, a_q} * {32'd0, b_q};

   // Divisor is forced to 1 for the zero and overflow cases so the dividers
   // never see an undefined operation; those results are overridden or dropped.
   assign div_by_zero = (b_q == 32'd0);
   assign div_ovf     = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
   assign sdiv_den    = (div_by_zero || div_ovf) ? 32'd1 : b_q;
   assign udiv_den    = div_by_zero ? 32'd1 : b_q;

   assign quot_s = div_ovf ? 32'h8000_0000 : 32'($signed(a_q) / $signed(sdiv_den));
   assign rem_s  = div_ovf ? 32'd0         : 32'($signed(a_q) % $signed(sdiv_den));
   assign quot_u = a_q / udiv_den;
   assign rem_u  = a_q % udiv_den;

   // NOTE: every signal written here gets a default first, so no path through
   // the case/if tree can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      unique case (state_q)
         IDLE: begin
            if (start_ok) begin
               a_d     = bus.A;
               b_d     = bus.B;
               op_d    = md_op_e'(bus.md_op);
               cnt_d   = is_mul_op ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
               state_d = RUN;
            end else if (!bus.start) begin
               if (bus.md_op == OP_MTHI) hi_d = bus.A;
               if (bus.md_op == OP_MTLO) lo_d = bus.A;
            end
         end

         RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
               case (op_q)
                  OP_MULT: begin
                     hi_d = prod_s[63:32];
                     lo_d = prod_s[31:0];
                  end
                  OP_MULTU: begin
                     hi_d = prod_u[63:32];
                     lo_d = prod_u[31:0];
                  end
                  OP_DIV: begin
                     if (!div_by_zero) begin
                        hi_d = rem_s;
                        lo_d = quot_s;
                     end
                  end
                  OP_DIVU: begin
                     if (!div_by_zero) begin
                        hi_d = rem_u;
                        lo_d = quot_u;
                     end
                  end
                  default: ;
               endcase
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= OP_NONE;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Read port and hazard request are purely combinational
   logic [31:0] md_out_d;

   always_comb begin
      md_out_d = '0;
      case (bus.md_op)
         OP_MFHI: md_out_d = hi_q;
         OP_MFLO: md_out_d = lo_q;
         default: ;
      endcase
   end

   assign bus.busy     = (state_q == RUN);
   assign bus.stall_md = bus.D_md_use & (bus.start | bus.busy);
   assign bus.md_out   = md_out_d;
   assign bus.HI       = hi_q;
   assign bus.LO       = lo_q;

endmodule
